tick_interval_meter: RTL and testbench

Measures the interval, in clock cycles, between consecutive single-cycle strobes on `tick_i`. Typical source: the periodic enable from a prescaler/counter stage. Reports each completed interval with a one-cycle valid pulse, tracks minimum and maximum intervals since the last clear, and flags a timeout when no strobe arrives within `MAX_COUNT` cycles. Used on the DE10-Lite designs to check tick generators and as a frequency/period readout source.

---
 rtl/tick_meter_pkg.sv | 12 +
 rtl/tick_interval_meter.sv | 116 +++++++++++
 tb/tb_tick_interval_meter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tick_meter_pkg.sv
// Shared types and defaults for the tick interval meter.
package tick_meter_pkg;

  localparam int unsigned DEFAULT_MAX_COUNT = 1023;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

endpackage

// File: rtl/tick_interval_meter.sv
// Measures cycles between strobes on tick_i and tracks min/max interval;
// flags a timeout when no strobe arrives within MAX_COUNT cycles.
//
// state   | meaning
// IDLE    | waiting for the first tick, which only arms the meter
// MEASURE | counting cycles since the last tick
// TIMEOUT | no tick for MAX_COUNT cycles; the interval is unknown
module tick_interval_meter
  import tick_meter_pkg::*;
#(
  parameter int unsigned MAX_COUNT = DEFAULT_MAX_COUNT,
  localparam int unsigned WIDTH = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] period_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o,
  output logic             timeout_o
);

  localparam logic [WIDTH-1:0] ACC_LAST  = WIDTH'(MAX_COUNT - 1);
  localparam logic [WIDTH-1:0] MIN_RESET = WIDTH'(MAX_COUNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [WIDTH-1:0] acc_inc;

  // acc never exceeds MAX_COUNT-1, so the increment cannot wrap
  assign acc_inc = acc_q + WIDTH'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    period_d  = period_q;
    min_d     = min_q;
    max_d     = max_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (clear_i) begin
      state_d   = IDLE;
      acc_d     = '0;
      period_d  = '0;
      min_d     = MIN_RESET;
      max_d     = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick_i) begin
            state_d = MEASURE;
            acc_d   = '0;
          end
        end
        MEASURE: begin
          if (tick_i) begin
            period_d = acc_inc;
            valid_d  = 1'b1;
            acc_d    = '0;
            if (acc_inc < min_q) min_d = acc_inc;
            if (acc_inc > max_q) max_d = acc_inc;
          end else if (acc_q == ACC_LAST) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
          end else begin
            acc_d = acc_inc;
          end
        end
        TIMEOUT: begin
          if (tick_i) begin
            state_d   = MEASURE;
            acc_d     = '0;
            timeout_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      period_q  <= '0;
      min_q     <= MIN_RESET;
      max_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      period_q  <= period_d;
      min_q     <= min_d;
      max_q     <= max_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign min_o     = min_q;
  assign max_o     = max_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_tick_interval_meter.sv
// Bench for tick_interval_meter: default-size and MAX_COUNT=16 instances,
// expected measurements queued at stimulus time and popped on valid_o.
module tb_tick_interval_meter;

  typedef struct packed {
    logic [31:0] p;
    logic [31:0] mn;
    logic [31:0] mx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, clear_a = 1'b0, tick_a = 1'b0;
  logic [9:0] period_a, min_a, max_a;
  logic       valid_a, timeout_a;

  logic       rst_b = 1'b1, clear_b = 1'b0, tick_b = 1'b0;
  logic [4:0] period_b, min_b, max_b;
  logic       valid_b, timeout_b;

  int errors = 0;
  int checks = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  int mn_a = 1023, mx_a = 0;
  int mn_b = 16,   mx_b = 0;

  tick_interval_meter dut_a (
    .clk_i(clk), .rst_i(rst_a), .tick_i(tick_a), .clear_i(clear_a),
    .period_o(period_a), .valid_o(valid_a), .min_o(min_a), .max_o(max_a),
    .timeout_o(timeout_a)
  );

  tick_interval_meter #(.MAX_COUNT(16)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .tick_i(tick_b), .clear_i(clear_b),
    .period_o(period_b), .valid_o(valid_b), .min_o(min_b), .max_o(max_b),
    .timeout_o(timeout_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_a(input int n);
    exp_t e;
    if (n < mn_a) mn_a = n;
    if (n > mx_a) mx_a = n;
    e.p = n; e.mn = mn_a; e.mx = mx_a;
    exp_a.push_back(e);
  endtask

  task automatic push_b(input int n);
    exp_t e;
    if (n < mn_b) mn_b = n;
    if (n > mx_b) mx_b = n;
    e.p = n; e.mn = mn_b; e.mx = mx_b;
    exp_b.push_back(e);
  endtask

  task automatic pulse_a();
    tick_a = 1'b1; step(1); tick_a = 1'b0;
  endtask

  task automatic pulse_b();
    tick_b = 1'b1; step(1); tick_b = 1'b0;
  endtask

  // next tick n cycles after the previous one, with its expected result queued
  task automatic interval_a(input int n);
    step(n - 1);
    push_a(n);
    pulse_a();
  endtask

  task automatic interval_b(input int n);
    step(n - 1);
    push_b(n);
    pulse_b();
  endtask

  task automatic clear_pulse_a();
    clear_a = 1'b1; step(1); clear_a = 1'b0;
    mn_a = 1023; mx_a = 0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_period"},  32'(period_a),  0);
    chk({tag, "_valid"},   32'(valid_a),   0);
    chk({tag, "_min"},     32'(min_a),     1023);
    chk({tag, "_max"},     32'(max_a),     0);
    chk({tag, "_timeout"}, 32'(timeout_a), 0);
  endtask

  always @(negedge clk) begin
    if (valid_a) begin
      checks++;
      assert (exp_a.size() > 0) else begin
        errors++;
        $error("FAIL a_unexpected_valid: observed period=%0d expected no valid", period_a);
      end
      if (exp_a.size() > 0) begin
        exp_t e;
        e = exp_a.pop_front();
        chk("a_period", 32'(period_a), e.p);
        chk("a_min",    32'(min_a),    e.mn);
        chk("a_max",    32'(max_a),    e.mx);
      end
    end
  end

  always @(negedge clk) begin
    if (valid_b) begin
      checks++;
      assert (exp_b.size() > 0) else begin
        errors++;
        $error("FAIL b_unexpected_valid: observed period=%0d expected no valid", period_b);
      end
      if (exp_b.size() > 0) begin
        exp_t e;
        e = exp_b.pop_front();
        chk("b_period", 32'(period_b), e.p);
        chk("b_min",    32'(min_b),    e.mn);
        chk("b_max",    32'(max_b),    e.mx);
      end
    end
  end

  initial begin
    step(2);
    rst_a = 1'b0;
    chk_reset_a("a_reset");

    // steady 51-cycle tick; first tick only arms
    pulse_a();
    repeat (4) interval_a(51);
    step(1);
    chk("a_51_timeout", 32'(timeout_a), 0);

    // varying intervals after a clear
    clear_pulse_a();
    chk_reset_a("a_clear");
    pulse_a();
    interval_a(10);
    interval_a(30);
    interval_a(20);
    step(2);
    chk("a_var_min", 32'(min_a), 10);
    chk("a_var_max", 32'(max_a), 30);
    chk("a_var_period", 32'(period_a), 20);

    // tick held high for 4 cycles from IDLE
    clear_pulse_a();
    tick_a = 1'b1;
    step(1);
    push_a(1); step(1);
    push_a(1); step(1);
    push_a(1); step(1);
    tick_a = 1'b0;
    step(2);
    chk("a_held_period", 32'(period_a), 1);
    chk("a_held_min", 32'(min_a), 1);

    // clear coincident with a tick mid-measurement
    clear_pulse_a();
    pulse_a();
    interval_a(7);
    step(5);
    clear_a = 1'b1; tick_a = 1'b1;
    step(1);
    clear_a = 1'b0; tick_a = 1'b0;
    mn_a = 1023; mx_a = 0;
    chk_reset_a("a_clr_tick");
    step(3);
    pulse_a();
    interval_a(12);
    step(2);
    chk("a_after_clr_period", 32'(period_a), 12);

    // small instance: boundary and timeout behaviour
    rst_b = 1'b0;
    chk("b_reset_min", 32'(min_b), 16);
    chk("b_reset_max", 32'(max_b), 0);
    chk("b_reset_timeout", 32'(timeout_b), 0);
    pulse_b();
    interval_b(16);
    chk("b_16_timeout", 32'(timeout_b), 0);
    interval_b(16);
    chk("b_16_timeout2", 32'(timeout_b), 0);
    step(15);
    chk("b_pre_timeout", 32'(timeout_b), 0);
    step(1);
    chk("b_timeout_rise", 32'(timeout_b), 1);
    step(5);
    chk("b_timeout_hold", 32'(timeout_b), 1);
    pulse_b();
    chk("b_recover_timeout", 32'(timeout_b), 0);
    chk("b_recover_valid", 32'(valid_b), 0);
    chk("b_recover_period", 32'(period_b), 16);
    chk("b_recover_min", 32'(min_b), 16);
    chk("b_recover_max", 32'(max_b), 16);
    interval_b(5);
    step(16);
    chk("b_timeout_again", 32'(timeout_b), 1);
    rst_b = 1'b1;
    step(1);
    rst_b = 1'b0;
    chk("b_rst_timeout", 32'(timeout_b), 0);
    chk("b_rst_min", 32'(min_b), 16);
    chk("b_rst_max", 32'(max_b), 0);
    chk("b_rst_period", 32'(period_b), 0);

    step(3);
    chk("a_queue_drained", 32'(exp_a.size()), 0);
    chk("b_queue_drained", 32'(exp_b.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
